// File: rtl/cache_sa_wb.sv
// Set-associative cache between a core load/store port and a line-wide RAM.
// Selectable write-back or write-through (both write-allocate), LRU ranks with
// invalid-way-first victim choice, and saturating hit/miss counters.
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   req_valid/req_ready        core request handshake (address, write_en, write_data)
//   resp_valid, read_data,miss one-cycle completion pulse with load data / miss flag
//   mem_req_valid/ready        RAM line request (mem_write_en, mem_address, mem_write_data)
//   mem_resp_valid, mem_read_data  returned refill line
//   hit_count, miss_count      saturating statistics
module cache_sa_wb #(
  parameter int unsigned RAM_ADDRESS_BITS   = 10,
  parameter int unsigned CACHE_ADDRESS_BITS = 5,
  parameter int unsigned DATA_BITS          = 32,
  parameter int unsigned ASOC_BITS          = 1,
  parameter int unsigned BLOCK_BITS         = 2,
  parameter int unsigned WRITE_BACK         = 1
) (
  input  logic                                     clk,
  input  logic                                     reset,
  input  logic                                     req_valid,
  output logic                                     req_ready,
  input  logic [RAM_ADDRESS_BITS-1:0]              address,
  input  logic                                     write_en,
  input  logic [DATA_BITS-1:0]                     write_data,
  output logic                                     resp_valid,
  output logic [DATA_BITS-1:0]                     read_data,
  output logic                                     miss,
  output logic                                     mem_req_valid,
  input  logic                                     mem_req_ready,
  output logic                                     mem_write_en,
  output logic [RAM_ADDRESS_BITS-1:0]              mem_address,
  output logic [(1<<BLOCK_BITS)*DATA_BITS-1:0]     mem_write_data,
  input  logic                                     mem_resp_valid,
  input  logic [(1<<BLOCK_BITS)*DATA_BITS-1:0]     mem_read_data,
  output logic [31:0]                              hit_count,
  output logic [31:0]                              miss_count
);
  localparam int unsigned INDEX_BITS = CACHE_ADDRESS_BITS - ASOC_BITS - BLOCK_BITS;
  localparam int unsigned TAG_BITS   = RAM_ADDRESS_BITS - INDEX_BITS - BLOCK_BITS;
  localparam int unsigned WAYS       = 1 << ASOC_BITS;
  localparam int unsigned SETS       = 1 << INDEX_BITS;
  localparam int unsigned LINE_BITS  = (1 << BLOCK_BITS) * DATA_BITS;
  // Direct-mapped keeps a 1-bit way/rank field that is always zero.
  localparam int unsigned WAY_W      = (ASOC_BITS > 0) ? ASOC_BITS : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_LOOKUP, S_WRITEBACK, S_REFILL_REQ, S_REFILL_WAIT, S_WTHRU, S_RESPOND
  } state_e;

  state_e state_q;

  logic                 valid_q [SETS][WAYS];
  logic                 dirty_q [SETS][WAYS];
  logic [TAG_BITS-1:0]  tag_q   [SETS][WAYS];
  logic [LINE_BITS-1:0] data_q  [SETS][WAYS];
  logic [WAY_W-1:0]     rank_q  [SETS][WAYS];

  logic [TAG_BITS-1:0]   req_tag_q;
  logic [INDEX_BITS-1:0] req_idx_q;
  logic [BLOCK_BITS-1:0] req_off_q;
  logic                  req_we_q;
  logic [DATA_BITS-1:0]  req_wdata_q;
  logic [WAY_W-1:0]      victim_q;
  logic                  was_miss_q;

  logic                        req_ready_q, resp_valid_q, miss_q;
  logic [DATA_BITS-1:0]        read_data_q;
  logic                        mem_req_valid_q, mem_write_en_q;
  logic [RAM_ADDRESS_BITS-1:0] mem_address_q;
  logic [LINE_BITS-1:0]        mem_write_data_q;
  logic [31:0]                 hit_count_q, miss_count_q;

  logic                 hit_c, refill_c, done_c;
  logic [WAY_W-1:0]     hit_way_c, victim_c, acc_way_c;
  logic [LINE_BITS-1:0] line_base_c, line_new_c;
  logic [DATA_BITS-1:0] word_c;
  logic [WAY_W-1:0]     rank_new_c [WAYS];
  logic [RAM_ADDRESS_BITS-1:0] line_addr_c;

  // Tag compare and victim choice for the latched request's set.
  always_comb begin
    hit_c     = 1'b0;
    hit_way_c = '0;
    victim_c  = '0;
    for (int w = 0; w < int'(WAYS); w++) begin
      if (!hit_c && valid_q[req_idx_q][w] && (tag_q[req_idx_q][w] == req_tag_q)) begin
        hit_c     = 1'b1;
        hit_way_c = WAY_W'(w);
      end
    end
    // Descending scans: the last match is the lowest index; invalid ways override LRU.
    for (int w = int'(WAYS) - 1; w >= 0; w--) begin
      if (rank_q[req_idx_q][w] == '0) victim_c = WAY_W'(w);
    end
    for (int w = int'(WAYS) - 1; w >= 0; w--) begin
      if (!valid_q[req_idx_q][w]) victim_c = WAY_W'(w);
    end
  end

  // Access completion: lookup hit or refill arrival share the same update path.
  always_comb begin
    refill_c    = (state_q == S_REFILL_WAIT) && mem_resp_valid;
    done_c      = ((state_q == S_LOOKUP) && hit_c) || refill_c;
    acc_way_c   = (state_q == S_REFILL_WAIT) ? victim_q : hit_way_c;
    line_base_c = (state_q == S_REFILL_WAIT) ? mem_read_data : data_q[req_idx_q][hit_way_c];
    word_c      = line_base_c[req_off_q*DATA_BITS +: DATA_BITS];
    line_new_c  = line_base_c;
    if (req_we_q) line_new_c[req_off_q*DATA_BITS +: DATA_BITS] = req_wdata_q;
    line_addr_c = {req_tag_q, req_idx_q, {BLOCK_BITS{1'b0}}};
    // Accessed way becomes most recent; ways above its old rank slide down.
    for (int w = 0; w < int'(WAYS); w++) begin
      if (WAY_W'(w) == acc_way_c)
        rank_new_c[w] = WAY_W'(WAYS - 1);
      else if (rank_q[req_idx_q][w] > rank_q[req_idx_q][acc_way_c])
        rank_new_c[w] = rank_q[req_idx_q][w] - WAY_W'(1);
      else
        rank_new_c[w] = rank_q[req_idx_q][w];
    end
  end

  // Controller FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= S_IDLE;
      req_ready_q     <= 1'b1;
      resp_valid_q    <= 1'b0;
      miss_q          <= 1'b0;
      read_data_q     <= '0;
      mem_req_valid_q <= 1'b0;
      mem_write_en_q  <= 1'b0;
      hit_count_q     <= '0;
      miss_count_q    <= '0;
      was_miss_q      <= 1'b0;
      for (int s = 0; s < int'(SETS); s++) begin
        for (int w = 0; w < int'(WAYS); w++) begin
          valid_q[s][w] <= 1'b0;
          dirty_q[s][w] <= 1'b0;
          rank_q[s][w]  <= (WAYS > 1) ? WAY_W'(w) : '0;
        end
      end
    end else begin
      resp_valid_q <= 1'b0;
      miss_q       <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (req_valid && req_ready_q) begin
            req_tag_q   <= address[RAM_ADDRESS_BITS-1 -: TAG_BITS];
            req_idx_q   <= address[BLOCK_BITS +: INDEX_BITS];
            req_off_q   <= address[BLOCK_BITS-1:0];
            req_we_q    <= write_en;
            req_wdata_q <= write_data;
            req_ready_q <= 1'b0;
            state_q     <= S_LOOKUP;
          end
        end
        S_LOOKUP: begin
          was_miss_q <= !hit_c;
          if (!hit_c) begin
            victim_q        <= victim_c;
            mem_req_valid_q <= 1'b1;
            if (valid_q[req_idx_q][victim_c] && dirty_q[req_idx_q][victim_c]) begin
              mem_write_en_q   <= 1'b1;
              mem_address_q    <= {tag_q[req_idx_q][victim_c], req_idx_q, {BLOCK_BITS{1'b0}}};
              mem_write_data_q <= data_q[req_idx_q][victim_c];
              state_q          <= S_WRITEBACK;
            end else begin
              mem_write_en_q <= 1'b0;
              mem_address_q  <= line_addr_c;
              state_q        <= S_REFILL_REQ;
            end
          end
        end
        S_WRITEBACK: begin
          if (mem_req_ready) begin
            mem_write_en_q <= 1'b0;
            mem_address_q  <= line_addr_c;
            state_q        <= S_REFILL_REQ;
          end
        end
        S_REFILL_REQ: begin
          if (mem_req_ready) begin
            mem_req_valid_q <= 1'b0;
            state_q         <= S_REFILL_WAIT;
          end
        end
        S_REFILL_WAIT: begin
          if (mem_resp_valid) begin
            valid_q[req_idx_q][victim_q] <= 1'b1;
            tag_q[req_idx_q][victim_q]   <= req_tag_q;
          end
        end
        S_WTHRU: begin
          if (mem_req_ready) begin
            mem_req_valid_q <= 1'b0;
            mem_write_en_q  <= 1'b0;
            resp_valid_q    <= 1'b1;
            miss_q          <= was_miss_q;
            read_data_q     <= '0;
            state_q         <= S_RESPOND;
          end
        end
        S_RESPOND: begin
          if (was_miss_q) begin
            if (miss_count_q != 32'hFFFF_FFFF) miss_count_q <= miss_count_q + 32'd1;
          end else begin
            if (hit_count_q != 32'hFFFF_FFFF) hit_count_q <= hit_count_q + 32'd1;
          end
          req_ready_q <= 1'b1;
          state_q     <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase

      if (done_c) begin
        for (int w = 0; w < int'(WAYS); w++) rank_q[req_idx_q][w] <= rank_new_c[w];
        if (req_we_q || refill_c) data_q[req_idx_q][acc_way_c] <= line_new_c;
        if (req_we_q)      dirty_q[req_idx_q][acc_way_c] <= (WRITE_BACK != 0);
        else if (refill_c) dirty_q[req_idx_q][acc_way_c] <= 1'b0;
        if ((WRITE_BACK == 0) && req_we_q) begin
          mem_req_valid_q  <= 1'b1;
          mem_write_en_q   <= 1'b1;
          mem_address_q    <= line_addr_c;
          mem_write_data_q <= line_new_c;
          state_q          <= S_WTHRU;
        end else begin
          resp_valid_q <= 1'b1;
          miss_q       <= refill_c;
          read_data_q  <= req_we_q ? '0 : word_c;
          state_q      <= S_RESPOND;
        end
      end
    end
  end

  assign req_ready      = req_ready_q;
  assign resp_valid     = resp_valid_q;
  assign read_data      = read_data_q;
  assign miss           = miss_q;
  assign mem_req_valid  = mem_req_valid_q;
  assign mem_write_en   = mem_write_en_q;
  assign mem_address    = mem_address_q;
  assign mem_write_data = mem_write_data_q;
  assign hit_count      = hit_count_q;
  assign miss_count     = miss_count_q;
endmodule

// File: tb/tb_cache_sa_wb.sv
// Bench for cache_sa_wb: a write-back and a write-through instance share one
// stimulus/RAM model; sel picks which one a request goes to.
module tb_cache_sa_wb;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset, sel;
  logic         req_valid, write_en, mem_req_ready, mem_resp_valid;
  logic [9:0]   address;
  logic [31:0]  write_data;
  logic [127:0] mem_read_data;

  logic         req_ready0, resp_valid0, miss0, mem_req_valid0, mem_write_en0;
  logic         req_ready1, resp_valid1, miss1, mem_req_valid1, mem_write_en1;
  logic [31:0]  read_data0, read_data1, hit_count0, hit_count1, miss_count0, miss_count1;
  logic [9:0]   mem_address0, mem_address1;
  logic [127:0] mem_write_data0, mem_write_data1;

  cache_sa_wb #(.WRITE_BACK(1)) u_wb (
    .clk(clk), .reset(reset), .req_valid(req_valid && !sel), .req_ready(req_ready0),
    .address(address), .write_en(write_en), .write_data(write_data),
    .resp_valid(resp_valid0), .read_data(read_data0), .miss(miss0),
    .mem_req_valid(mem_req_valid0), .mem_req_ready(mem_req_ready && !sel),
    .mem_write_en(mem_write_en0), .mem_address(mem_address0), .mem_write_data(mem_write_data0),
    .mem_resp_valid(mem_resp_valid && !sel), .mem_read_data(mem_read_data),
    .hit_count(hit_count0), .miss_count(miss_count0));

  cache_sa_wb #(.WRITE_BACK(0)) u_wt (
    .clk(clk), .reset(reset), .req_valid(req_valid && sel), .req_ready(req_ready1),
    .address(address), .write_en(write_en), .write_data(write_data),
    .resp_valid(resp_valid1), .read_data(read_data1), .miss(miss1),
    .mem_req_valid(mem_req_valid1), .mem_req_ready(mem_req_ready && sel),
    .mem_write_en(mem_write_en1), .mem_address(mem_address1), .mem_write_data(mem_write_data1),
    .mem_resp_valid(mem_resp_valid && sel), .mem_read_data(mem_read_data),
    .hit_count(hit_count1), .miss_count(miss_count1));

  logic         v_req_ready, v_resp_valid, v_miss, v_mem_req_valid, v_mem_write_en;
  logic [31:0]  v_read_data;
  logic [9:0]   v_mem_address;
  logic [127:0] v_mem_write_data;
  assign v_req_ready      = sel ? req_ready1      : req_ready0;
  assign v_resp_valid     = sel ? resp_valid1     : resp_valid0;
  assign v_miss           = sel ? miss1           : miss0;
  assign v_mem_req_valid  = sel ? mem_req_valid1  : mem_req_valid0;
  assign v_mem_write_en   = sel ? mem_write_en1   : mem_write_en0;
  assign v_read_data      = sel ? read_data1      : read_data0;
  assign v_mem_address    = sel ? mem_address1    : mem_address0;
  assign v_mem_write_data = sel ? mem_write_data1 : mem_write_data0;

  logic [127:0] ram [256];
  int total = 0;
  int bad   = 0;

  typedef struct {
    logic dut; logic [9:0] a; logic we; logic [31:0] wd; int stall;
    logic [31:0] rd; logic ms; int lat; int nwb; int nrd;
    logic [9:0] wb_addr; logic [127:0] wb_data; logic [9:0] rd_addr;
  } vec_t;

  typedef struct {
    logic [31:0] rd; logic ms; int lat; int nwb; int nrd;
    logic [9:0] wb_addr; logic [127:0] wb_data; logic [9:0] rd_addr;
    logic stable_ok; logic timeout;
  } res_t;

  vec_t tab1 [15];
  vec_t tab2 [5];

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic d, input logic [9:0] a, input logic we, input logic [31:0] wd,
                              input int st, input logic [31:0] rd, input logic ms, input int lat,
                              input int nwb, input logic [9:0] wba, input logic [127:0] wbd,
                              input int nrd, input logic [9:0] rda);
    vec_t v;
    v.dut = d; v.a = a; v.we = we; v.wd = wd; v.stall = st; v.rd = rd; v.ms = ms; v.lat = lat;
    v.nwb = nwb; v.wb_addr = wba; v.wb_data = wbd; v.nrd = nrd; v.rd_addr = rda;
    return v;
  endfunction

  // Issue one request at a negedge and act as the RAM until the response pulse.
  task automatic run_req(input logic [9:0] a, input logic we, input logic [31:0] wd,
                         input int stall_in, output res_t r);
    int stall;
    logic resp_pend, snapped;
    logic [127:0] pend_line, snap_data;
    logic [9:0] snap_addr;
    r.rd = '0; r.ms = 1'b0; r.lat = 0; r.nwb = 0; r.nrd = 0; r.wb_addr = '0;
    r.wb_data = '0; r.rd_addr = '0; r.stable_ok = 1'b1; r.timeout = 1'b1;
    stall = stall_in; resp_pend = 1'b0; snapped = 1'b0; pend_line = '0;
    snap_data = '0; snap_addr = '0;
    req_valid = 1'b1; address = a; write_en = we; write_data = wd;
    @(negedge clk);
    req_valid = 1'b0;
    for (int cyc = 1; cyc < 60; cyc++) begin
      mem_resp_valid = 1'b0;
      mem_req_ready  = 1'b0;
      if (resp_pend) begin
        mem_resp_valid = 1'b1;
        mem_read_data  = pend_line;
        resp_pend      = 1'b0;
      end
      if (v_resp_valid) begin
        r.rd = v_read_data; r.ms = v_miss; r.lat = cyc; r.timeout = 1'b0;
        break;
      end
      if (v_mem_req_valid) begin
        if (snapped && (v_mem_address !== snap_addr || v_mem_write_data !== snap_data || !v_mem_write_en))
          r.stable_ok = 1'b0;
        if (stall > 0) begin
          if (!snapped) begin
            snapped = 1'b1; snap_addr = v_mem_address; snap_data = v_mem_write_data;
          end
          if (v_req_ready) r.stable_ok = 1'b0;
          stall--;
        end else begin
          snapped = 1'b0;
          mem_req_ready = 1'b1;
          if (v_mem_write_en) begin
            r.nwb++; r.wb_addr = v_mem_address; r.wb_data = v_mem_write_data;
            ram[v_mem_address[9:2]] = v_mem_write_data;
          end else begin
            r.nrd++; r.rd_addr = v_mem_address;
            pend_line = ram[v_mem_address[9:2]];
            resp_pend = 1'b1;
          end
        end
      end
      @(negedge clk);
    end
    mem_resp_valid = 1'b0;
    mem_req_ready  = 1'b0;
    @(negedge clk);
  endtask

  task automatic apply_vec(input vec_t v, input string tag);
    res_t r;
    sel = v.dut;
    check({tag, " req_ready"}, v_req_ready, 1'b1);
    run_req(v.a, v.we, v.wd, v.stall, r);
    check({tag, " timeout"}, r.timeout, 1'b0);
    check({tag, " read_data"}, r.rd, v.rd);
    check({tag, " miss"}, r.ms, v.ms);
    check({tag, " mem writes"}, r.nwb, v.nwb);
    check({tag, " mem reads"}, r.nrd, v.nrd);
    if (v.lat > 0) check({tag, " latency"}, r.lat, v.lat);
    if (v.nwb > 0) begin
      check({tag, " wb addr"}, r.wb_addr, v.wb_addr);
      check({tag, " wb data"}, r.wb_data, v.wb_data);
    end
    if (v.nrd > 0) check({tag, " refill addr"}, r.rd_addr, v.rd_addr);
    if (v.stall > 0) check({tag, " stall stable"}, r.stable_ok, 1'b1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic got, seen;
    reset = 1'b1; sel = 1'b0; req_valid = 1'b0; write_en = 1'b0; address = '0; write_data = '0;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_read_data = '0;
    for (int l = 0; l < 256; l++)
      for (int w = 0; w < 4; w++) ram[l][w*32 +: 32] = 32'hC000_0000 + 32'(l * 16 + w);

    // Write-back instance (dut 0) then write-through instance (dut 1).
    tab1[0]  = mk(0, 10'h010, 0, 0, 0, 32'hC0000040, 1, 0, 0, 0, 0, 1, 10'h010);
    tab1[1]  = mk(0, 10'h012, 0, 0, 0, 32'hC0000042, 0, 2, 0, 0, 0, 0, 0);
    tab1[2]  = mk(0, 10'h011, 1, 32'hDEADBEEF, 0, 0, 0, 2, 0, 0, 0, 0, 0);
    tab1[3]  = mk(0, 10'h110, 0, 0, 0, 32'hC0000440, 1, 0, 0, 0, 0, 1, 10'h110);
    tab1[4]  = mk(0, 10'h210, 0, 0, 5, 32'hC0000840, 1, 0, 1, 10'h010,
                  128'hC0000043_C0000042_DEADBEEF_C0000040, 1, 10'h210);
    tab1[5]  = mk(0, 10'h011, 0, 0, 0, 32'hDEADBEEF, 1, 0, 0, 0, 0, 1, 10'h010);
    tab1[6]  = mk(0, 10'h210, 0, 0, 0, 32'hC0000840, 0, 2, 0, 0, 0, 0, 0);
    tab1[7]  = mk(0, 10'h214, 1, 32'h12345678, 0, 0, 1, 0, 0, 0, 0, 1, 10'h214);
    tab1[8]  = mk(0, 10'h214, 0, 0, 0, 32'h12345678, 0, 2, 0, 0, 0, 0, 0);
    tab1[9]  = mk(1, 10'h010, 0, 0, 0, 32'hC0000040, 1, 0, 0, 0, 0, 1, 10'h010);
    tab1[10] = mk(1, 10'h012, 1, 32'hCAFEF00D, 0, 0, 0, 0, 1, 10'h010,
                  128'hC0000043_CAFEF00D_DEADBEEF_C0000040, 0, 0);
    tab1[11] = mk(1, 10'h110, 0, 0, 0, 32'hC0000440, 1, 0, 0, 0, 0, 1, 10'h110);
    tab1[12] = mk(1, 10'h210, 0, 0, 0, 32'hC0000840, 1, 0, 0, 0, 0, 1, 10'h210);
    tab1[13] = mk(1, 10'h310, 1, 32'h11112222, 0, 0, 1, 0, 1, 10'h310,
                  128'hC0000C43_C0000C42_C0000C41_11112222, 1, 10'h310);
    tab1[14] = mk(1, 10'h012, 0, 0, 0, 32'hCAFEF00D, 1, 0, 0, 0, 0, 1, 10'h010);

    tab2[0] = mk(0, 10'h030, 0, 0, 0, 32'hC00000C0, 1, 0, 0, 0, 0, 1, 10'h030);
    tab2[1] = mk(0, 10'h031, 0, 0, 0, 32'hC00000C1, 0, 2, 0, 0, 0, 0, 0);
    tab2[2] = mk(0, 10'h032, 0, 0, 0, 32'hC00000C2, 0, 2, 0, 0, 0, 0, 0);
    tab2[3] = mk(0, 10'h130, 0, 0, 0, 32'hC00004C0, 1, 0, 0, 0, 0, 1, 10'h130);
    tab2[4] = mk(0, 10'h230, 0, 0, 0, 32'hC00008C0, 1, 0, 0, 0, 0, 1, 10'h230);

    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    check("reset req_ready", req_ready0, 1'b1);
    check("reset resp_valid", resp_valid0, 1'b0);
    check("reset miss", miss0, 1'b0);
    check("reset mem_req_valid", mem_req_valid0, 1'b0);
    check("reset mem_write_en", mem_write_en0, 1'b0);
    check("reset read_data", read_data0, 32'h0);
    check("reset hit_count", hit_count0, 32'h0);
    check("reset miss_count", miss_count0, 32'h0);
    check("reset wt req_ready", req_ready1, 1'b1);

    for (int i = 0; i < 15; i++) apply_vec(tab1[i], $sformatf("t1[%0d]", i));
    check("wb hit_count", hit_count0, 32'd4);
    check("wb miss_count", miss_count0, 32'd5);
    check("wt hit_count", hit_count1, 32'd1);
    check("wt miss_count", miss_count1, 32'd5);

    // Reset while waiting for a refill: the late line must not be installed.
    sel = 1'b0; reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    req_valid = 1'b1; address = 10'h030; write_en = 1'b0;
    @(negedge clk); req_valid = 1'b0;
    got = 1'b0;
    for (int c = 0; c < 20 && !got; c++) begin
      if (mem_req_valid0 && !mem_write_en0) begin
        mem_req_ready = 1'b1; got = 1'b1;
      end
      @(negedge clk);
    end
    mem_req_ready = 1'b0;
    check("abort refill issued", got, 1'b1);
    reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    check("abort mem_req_valid", mem_req_valid0, 1'b0);
    check("abort req_ready", req_ready0, 1'b1);
    mem_resp_valid = 1'b1; mem_read_data = 128'hBAD0BAD0_BAD0BAD0_BAD0BAD0_BAD0BAD0;
    seen = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      mem_resp_valid = 1'b0;
      if (resp_valid0 || mem_req_valid0) seen = 1'b1;
    end
    check("late resp ignored", seen, 1'b0);

    for (int i = 0; i < 5; i++) apply_vec(tab2[i], $sformatf("t2[%0d]", i));
    check("final hit_count", hit_count0, 32'd2);
    check("final miss_count", miss_count0, 32'd3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/cache_sa_wb.md
Name: cache_sa_wb

Overview:
- Parametrised set-associative cache sitting between a core load/store port and a block-wide RAM interface.
- Successor to the current single-cycle cache. Replaces ad-hoc stall logic with an explicit FSM and ready/valid handshakes on both sides.
- Adds: true victim write-back with stall until accepted; selectable write-back or write-through mode; invalid-way-first victim selection; hit/miss statistics counters.

Parameters:
- RAM_ADDRESS_BITS, 10, word-address width of the RAM.
- CACHE_ADDRESS_BITS, 5, log2 of cache capacity in words.
- DATA_BITS, 32, word width.
- ASOC_BITS, 1, log2 of ways; 0 gives direct-mapped.
- BLOCK_BITS, 2, log2 of words per line.
- WRITE_BACK, 1, selects write mode: 1 = write-back/write-allocate; 0 = write-through/write-allocate.
- Derived: INDEX_BITS = CACHE_ADDRESS_BITS-ASOC_BITS-BLOCK_BITS; TAG_BITS = RAM_ADDRESS_BITS-INDEX_BITS-BLOCK_BITS.

Ports:
- clk  in  1  clock; single clock domain.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  core request valid.
- req_ready  out  1  cache can accept a request.
- address  in  RAM_ADDRESS_BITS  word address.
- write_en  in  1  1 = write, 0 = read.
- write_data  in  DATA_BITS  store data.
- resp_valid  out  1  one-cycle pulse; request complete.
- read_data  out  DATA_BITS  load data; valid with resp_valid.
- miss  out  1  pulse with resp_valid if the request missed.
- mem_req_valid  out  1  RAM request valid.
- mem_req_ready  in  1  RAM accepts request.
- mem_write_en  out  1  1 = line write, 0 = line read.
- mem_address  out  RAM_ADDRESS_BITS  line-aligned; offset bits are 0.
- mem_write_data  out  2**BLOCK_BITS*DATA_BITS  line data.
- mem_resp_valid  in  1  read line returned.
- mem_read_data  in  2**BLOCK_BITS*DATA_BITS  returned line.
- hit_count  out  32  saturating count of hits.
- miss_count  out  32  saturating count of misses.

Behaviour:
- Address split: {tag, index, offset}, MSB to LSB.
- Line state: valid, dirty, tag, data, lru rank (ASOC_BITS wide).
- Reset values, applied in one cycle:
  - All valid and dirty bits = 0; way w rank = w; data array not reset.
  - State = IDLE; counters = 0.
  - req_ready=1; resp_valid, miss, mem_req_valid and mem_write_en = 0; read_data = 0.
- IDLE: req_ready=1. Accept on req_valid&req_ready; latch the request; go to LOOKUP. req_ready=0 in every other state.
- LOOKUP, 1 cycle: compare tag across all ways of the set.
  - Hit: a read captures the word; a write updates the word and sets dirty (WRITE_BACK=1). Go to WTHRU if WRITE_BACK=0 and write, else RESPOND.
  - Miss: choose victim = lowest-index invalid way, else the way with rank 0. Go to WRITEBACK if the victim is valid&dirty, else REFILL_REQ.
- WRITEBACK: mem_req_valid=1, mem_write_en=1, mem_address={victim tag,index,0}, mem_write_data=victim line. Hold all outputs stable until mem_req_ready; then go to REFILL_REQ.
- REFILL_REQ: mem_req_valid=1, mem_write_en=0, mem_address={tag,index,0}. Go to REFILL_WAIT on mem_req_ready.
- REFILL_WAIT: on mem_resp_valid, install the line with valid=1, dirty=0.
  - Write request: merge write_data at offset; set dirty if WRITE_BACK=1.
  - Next state: WTHRU if WRITE_BACK=0 and write, else RESPOND.
- WTHRU: mem write of the full updated line to {tag,index,0}; hold until mem_req_ready; then go to RESPOND. The dirty bit is never set in this mode.
- RESPOND: resp_valid=1 for one cycle; read_data valid for reads, 0 for writes; miss=1 if a miss occurred. Go to IDLE.
- Latency: hit response is 2 cycles after the accept edge; no memory traffic on a read hit.
- LRU update, at the LOOKUP hit or the refill install:
  - Accessed way rank := 2**ASOC_BITS-1.
  - Ways with rank greater than the accessed way's old rank decrement by 1.
  - Ranks remain a permutation at all times.
  - ASOC_BITS=0: no LRU state; way 0 is always the victim.
- Counters: increment in RESPOND (hit or miss); saturate at 32'hFFFFFFFF.
- Ignored inputs: mem_resp_valid outside REFILL_WAIT; mem_req_ready when mem_req_valid=0.
- Reset mid-operation: next cycle is IDLE with mem_req_valid=0. The outstanding RAM transaction is abandoned; the line being refilled is not installed.

Test Plan (defaults: 4 sets, 2 ways, 4-word lines, tag=addr[9:4]):
- Reset; read 0x010 -> mem read to 0x010; return {D3,D2,D1,D0}; resp_valid with read_data=D0 and miss=1. Then read 0x012 -> resp_valid 2 cycles after accept, read_data=D2, miss=0, no mem_req_valid.
- Write 0x011=0xDEADBEEF (hit); read 0x110 (miss, fills way 1); read 0x210 -> WRITEBACK to 0x010 with word1=0xDEADBEEF, then refill read 0x210.
- Hold mem_req_ready=0 for 5 cycles during WRITEBACK -> mem_req_valid, mem_address and mem_write_data stable; req_ready=0; no resp_valid.
- WRITE_BACK=0: write hit at 0x012 -> one mem write of the line to 0x010; a later eviction of that line issues no write-back.
- Assert reset during REFILL_WAIT -> next cycle mem_req_valid=0 and req_ready=1. A late mem_resp_valid is ignored; re-reading the same address misses again.
- After 3 misses and 2 hits from reset -> miss_count=3, hit_count=2.
